// File: rtl/dmem_arb_pkg.sv
// Types shared by the dcache port arbiter and its round-robin picker.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic           ren;
    logic           wen;
    logic           atomic;
    isa_pkg::word_t addr;
    isa_pkg::word_t store;
  } req_t;
endpackage

// File: rtl/isa_pkg.sv
// ISA-wide base types shared by datapath and memory-side blocks.
package isa_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/rr_picker.sv
// Round-robin finder: first eligible requester at or after ptr, wrapping.
// Purely combinational, no backpressure of its own.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] gnt,
  output logic          vld
);
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!vld && req[idx] && mask[idx]) begin
        vld = 1'b1;
        gnt = idx;
      end
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// N-port round-robin arbiter onto one dcache port; request held until dhit, hit pulse one cycle later.
// Latency: request -> cache cycle 1, port_dhit the cycle after dhit; losers simply wait.
// Optional reservation lock for atomics under DMEM_ARB_ATOMIC_LOCK_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NPORTS       = 4,
  parameter int WORD_W       = isa_pkg::WORD_W,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NPORTS-1:0]             port_ren,
  input  logic [NPORTS-1:0]             port_wen,
  input  logic [NPORTS-1:0]             port_atomic,
  input  logic [NPORTS-1:0]             port_halt,
  input  logic [NPORTS-1:0][WORD_W-1:0] port_addr,
  input  logic [NPORTS-1:0][WORD_W-1:0] port_store,
  output logic [NPORTS-1:0]             port_dhit,
  output logic [WORD_W-1:0]             port_load,
  output logic [NPORTS-1:0]             port_flushed,
  output logic                          dmemREN,
  output logic                          dmemWEN,
  output logic                          datomic,
  output logic [WORD_W-1:0]             dmemaddr,
  output logic [WORD_W-1:0]             dmemstore,
  output logic                          halt,
  input  logic                          dhit,
  input  logic [WORD_W-1:0]             dmemload,
  input  logic                          flushed
);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  if (NPORTS < 2 || NPORTS > 16 || LOCK_TIMEOUT < 1) begin : g_cfg_err
    $error("dmem_port_arbiter: parameter out of range");
  end

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     rr_ptr, grant, pick;
  logic              pick_vld;
  logic              busy;
  req_t              lat;
  logic [NPORTS-1:0] req_any, elig;

  assign req_any = port_ren | port_wen;

  rr_picker #(.N(NPORTS), .IW(IW)) u_picker (
    .req  (req_any),
    .ptr  (rr_ptr),
    .mask (elig),
    .gnt  (pick),
    .vld  (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = BUSY;
      BUSY:    if (dhit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      lat       <= '0;
      port_dhit <= '0;
      port_load <= '0;
    end else begin
      state     <= state_nxt;
      port_dhit <= '0;
      if (state == IDLE && pick_vld) begin
        grant      <= pick;
        lat.ren    <= port_ren[pick];
        lat.wen    <= port_wen[pick];
        lat.atomic <= port_atomic[pick];
        lat.addr   <= port_addr[pick];
        lat.store  <= port_store[pick];
      end
      if (state == BUSY && dhit) begin
        port_load        <= dmemload;
        port_dhit[grant] <= 1'b1;
        rr_ptr           <= (grant == IW'(NPORTS-1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Write wins when a port raises both ren and wen.
  assign busy      = (state == BUSY);
  assign dmemREN   = busy & lat.ren & ~lat.wen;
  assign dmemWEN   = busy & lat.wen;
  assign datomic   = busy & lat.atomic;
  assign dmemaddr  = busy ? lat.addr  : '0;
  assign dmemstore = busy ? lat.store : '0;

  assign halt         = (state == IDLE) & ~(|req_any) & (&port_halt);
  assign port_flushed = {NPORTS{flushed}};

`ifdef DMEM_ARB_ATOMIC_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic          lock_valid;
  logic [IW-1:0] lock_port;
  logic [CW-1:0] lock_cnt;

  assign elig = lock_valid ? ({{(NPORTS-1){1'b0}}, 1'b1} << lock_port) : {NPORTS{1'b1}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_valid <= 1'b0;
      lock_port  <= '0;
      lock_cnt   <= '0;
    end else begin
      // Timeout only runs over consecutive idle cycles where the owner stays quiet.
      if (state == IDLE && lock_valid && !req_any[lock_port]) begin
        if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          lock_valid <= 1'b0;
          lock_cnt   <= '0;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else begin
        lock_cnt <= '0;
      end
      if (state == IDLE && pick_vld && port_ren[pick] && !port_wen[pick] && port_atomic[pick]) begin
        lock_valid <= 1'b1;
        lock_port  <= pick;
      end
      if (state == BUSY && dhit && (lat.wen || !lat.atomic)) lock_valid <= 1'b0;
    end
  end
`else
  assign elig = {NPORTS{1'b1}};
`endif
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Parametrised N-channel successor to the single datapath-to-dcache port.
- Sits between NPORTS datapath requesters (tensor/scalar lanes) and one dcache port.
- Round-robin arbitration; the granted request is registered and held on the cache side until dhit.
- The read result and a one-cycle hit pulse are returned to the winning port only; halt is aggregated and flushed is fanned out.

Parameters:
- NPORTS, 4, number of requesting channels (2..16).
- WORD_W, 32, address/data width; equals width of isa_pkg word_t.
- LOCK_TIMEOUT, 64, idle cycles before an atomic reservation lock is dropped (used only with macro).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- port_ren  in  NPORTS  per-port read request.
- port_wen  in  NPORTS  per-port write request.
- port_atomic  in  NPORTS  per-port atomic qualifier.
- port_halt  in  NPORTS  per-port halt.
- port_addr  in  NPORTS x WORD_W  per-port address.
- port_store  in  NPORTS x WORD_W  per-port store data.
- port_dhit  out  NPORTS  one-cycle completion pulse.
- port_load  out  WORD_W  registered load data, valid when any port_dhit bit is high.
- port_flushed  out  NPORTS  copy of dcache flushed to every port.
- dmemREN, dmemWEN, datomic  out  1  cache-side request.
- dmemaddr, dmemstore  out  WORD_W  cache-side request.
- halt  out  1  aggregated halt.
- dhit  in  1  cache hit.
- dmemload  in  WORD_W  cache load data.
- flushed  in  1  cache flush done.

Behaviour:
- Reset: state IDLE, rr_ptr=0, all outputs 0, latched request cleared. Reset during BUSY abandons the transaction; no port_dhit is issued.
- FSM states:
  - IDLE: if any port requests (ren|wen), pick the first requester at or after rr_ptr, wrapping modulo NPORTS. Latch its index, addr, store, ren, wen and atomic. Go BUSY.
  - BUSY: drive the latched request on dmemREN/dmemWEN/datomic/dmemaddr/dmemstore. On dhit: capture dmemload into port_load, set port_dhit[grant] next cycle, set rr_ptr=(grant+1) mod NPORTS, go DONE.
  - DONE: cache outputs are 0. The port_dhit pulse is high this cycle only. Requests are ignored this cycle, since the winner still asserts them. Go IDLE.
- Latency: request seen in cycle 0 -> cache request in cycle 1 -> dhit in cycle k (k>=1) -> port_dhit in cycle k+1 -> next grant possible at cycle k+2.
- Requesters must hold their request stable until they see port_dhit. Changes to a granted port's inputs after latching are ignored.
- ren and wen both high on one port: treated as a write (dmemREN=0, dmemWEN=1).
- dhit in IDLE or DONE is ignored.
- port_load holds its value until the next capture.
- halt = &port_halt, and is asserted only while the FSM is IDLE and no request is pending; otherwise halt=0 until the transaction drains.
- port_flushed[i] = flushed (combinational fan-out).

Optional Feature:
- Macro DMEM_ARB_ATOMIC_LOCK_EN.
- With the macro:
  - A granted atomic read (ren & atomic) sets lock_valid and lock_port=grant. While locked, only lock_port is eligible; other ports wait.
  - The lock is released on completion of any write from lock_port, on a non-atomic access from lock_port, or after LOCK_TIMEOUT consecutive IDLE cycles with no request from lock_port.
  - Reset clears the lock.
- Without the macro: atomic is passed through to datomic only; no lock state exists.

Decomposition:
- Shared package dmem_arb_pkg: arb_state_t enum (IDLE, BUSY, DONE) and a req_t struct (ren, wen, atomic, addr, store) built from isa_pkg word_t.
- Sub-module rr_picker: combinational round-robin first-one-from-pointer finder.
  - Inputs: req vector, rr_ptr, eligibility mask.
  - Outputs: grant index and valid.

Test Plan:
- Single read: port 2 ren, addr 0x100; dhit in the 3rd cache cycle with dmemload 0xDEADBEEF -> dmemREN held 3 cycles, port_dhit=4'b0100 for one cycle, port_load=0xDEADBEEF.
- All 4 ports request continuously, dhit every cycle -> grants in order 0,1,2,3,0; each port_dhit is separated by 3 cycles.
- Port 1 holds ren and wen, store 0x55 -> dmemWEN=1, dmemREN=0, dmemstore=0x55.
- Reset asserted during BUSY, then dhit -> outputs 0, no port_dhit, the next grant starts from port 0.
- port_halt=4'b1111 while port 3 is BUSY -> halt=0 until DONE->IDLE, then halt=1; flushed=1 -> port_flushed=4'b1111.
- With DMEM_ARB_ATOMIC_LOCK_EN: port 0 atomic read, port 1 requesting -> port 1 is not granted until port 0's atomic write completes, or until 64 idle cycles pass.
